jtag_csr_ctrl: RTL

//  Owns the 8 x 32-bit CSR file behind the JTAG data register and schedules access to it between
//  the JTAG DR port (address/data update pulses) and a local host req/gnt port. Sits beside the DR

---
 rtl/jtag_pkg.sv | 14 +
 rtl/jtag_csr_ctrl_if.sv | 27 ++
 rtl/jtag_csr_regfile.sv | 48 ++++
 rtl/jtag_csr_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the JTAG CSR controller
package jtag_pkg;
  localparam int NUM_REGS = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEF_STARVE_LIM = 4;
  localparam logic [7:0] DEF_VERSION = 8'h01;
  localparam logic [ADDR_W-1:0] CSR_STATUS_ADDR = 3'd7;
  localparam int CSR_LOCK_BIT = 0;
  typedef enum logic [1:0] {IDLE, JTAG_WR, HOST_WR, HOST_RD} csr_state_e;
  function automatic logic [DATA_W-1:0] status_word(input logic [7:0] version, input logic lock, input logic [7:0] drop);
    status_word = {version, {(DATA_W-17){1'b0}}, lock, drop};
  endfunction
endpackage

// File: rtl/jtag_csr_ctrl_if.sv
// jtag_csr_ctrl_if: JTAG DR port and host req/gnt port of the CSR controller
interface jtag_csr_ctrl_if;
  import jtag_pkg::*;
  logic dr_csr_addr_valid;
  logic [ADDR_W-1:0] dr_csr_addr;
  logic dr_csr_data_valid;
  logic [DATA_W-1:0] dr_csr_data;
  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_data;
  logic host_req;
  logic host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic host_gnt;
  logic host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  modport master (
    output dr_csr_addr_valid, dr_csr_addr, dr_csr_data_valid, dr_csr_data,
    output host_req, host_we, host_addr, host_wdata,
    input csr_addr, csr_data, host_gnt, host_rvalid, host_rdata
  );
  modport slave (
    input dr_csr_addr_valid, dr_csr_addr, dr_csr_data_valid, dr_csr_data,
    input host_req, host_we, host_addr, host_wdata,
    output csr_addr, csr_data, host_gnt, host_rvalid, host_rdata
  );
endinterface

// File: rtl/jtag_csr_regfile.sv
// jtag_csr_regfile: CSR storage with one write port, two registered read ports and the status view (JTAG_CSR_LOCK_EN enables the CSR0 lock bit)
module jtag_csr_regfile import jtag_pkg::*; #(
  parameter logic [7:0] VERSION = DEF_VERSION
) (
  input  logic tck,
  input  logic reset,
  input  logic we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [7:0] drop_cnt,
  output logic lock
);
  logic [DATA_W-1:0] mem [NUM_REGS-1];
  logic [DATA_W-1:0] view [NUM_REGS];
`ifdef JTAG_CSR_LOCK_EN
  assign lock = mem[0][CSR_LOCK_BIT];
`else
  assign lock = 1'b0;
`endif
  // storage only for addresses 0..6; status address is composed, never stored
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS-1; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS-1; i++) if (we && waddr == ADDR_W'(i)) mem[i] <= wdata;
    end
  end
  // address map as seen by both read ports
  always_comb begin
    for (int i = 0; i < NUM_REGS-1; i++) view[i] = mem[i];
    view[NUM_REGS-1] = status_word(VERSION, lock, drop_cnt);
  end
  // port a follows the DR address every cycle; port b only drives data during a host read
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= view[raddr_a];
      rdata_b <= re_b ? view[raddr_b] : '0;
    end
  end
endmodule

// File: rtl/jtag_csr_ctrl.sv
// jtag_csr_ctrl: arbitrates JTAG DR and host access to the CSR file with starvation protection (JTAG_CSR_LOCK_EN enables host write lock)
module jtag_csr_ctrl import jtag_pkg::*; #(
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter logic [7:0] VERSION = DEF_VERSION
) (
  input logic tck,
  input logic reset,
  jtag_csr_ctrl_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  csr_state_e state, state_nx;
  logic jtag_pend, pend_eff, grant, we, lock, host_blk, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] csr_addr, j_addr, h_addr, waddr;
  logic [DATA_W-1:0] j_data, h_wdata, host_wd, wdata;
  logic [SW-1:0] starve_cnt;
  logic [7:0] drop_cnt;
  assign bus.csr_addr = csr_addr;
  assign bus.host_gnt = host_gnt;
  assign bus.host_rvalid = host_rvalid;
  // a data pulse arriving this cycle already counts as pending so it beats a simultaneous host request
  always_comb begin
    pend_eff = jtag_pend || bus.dr_csr_data_valid;
    grant = state == IDLE && bus.host_req && (starve_cnt == SW'(STARVE_LIM) || !pend_eff);
    state_nx = state != IDLE ? IDLE : grant ? (bus.host_we ? HOST_WR : HOST_RD) : pend_eff ? JTAG_WR : IDLE;
    host_blk = lock && h_addr != '0;
    host_wd = h_addr == '0 ? h_wdata | (DATA_W'(lock) << CSR_LOCK_BIT) : h_wdata;
    we = state == JTAG_WR || (state == HOST_WR && !host_blk);
    waddr = state == HOST_WR ? h_addr : j_addr;
    wdata = state == HOST_WR ? host_wd : j_data;
  end
  // arbitration state register
  always_ff @(posedge tck or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // host handshake and request capture at grant
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      host_gnt <= 1'b0;
      host_rvalid <= 1'b0;
      h_addr <= '0;
      h_wdata <= '0;
    end else begin
      host_gnt <= grant;
      host_rvalid <= state == HOST_RD;
      if (grant) begin
        h_addr <= bus.host_addr;
        h_wdata <= bus.host_wdata;
      end
    end
  end
  // JTAG address latch, single-entry pending write and overrun counter
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      csr_addr <= '0;
      j_addr <= '0;
      j_data <= '0;
      jtag_pend <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (bus.dr_csr_addr_valid) csr_addr <= bus.dr_csr_addr;
      if (bus.dr_csr_data_valid) begin
        j_addr <= bus.dr_csr_addr_valid ? bus.dr_csr_addr : csr_addr;
        j_data <= bus.dr_csr_data;
      end
      jtag_pend <= bus.dr_csr_data_valid || (jtag_pend && state != JTAG_WR);
      if (bus.dr_csr_data_valid && jtag_pend && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
  // cycles a requesting host has been passed over while idle
  always_ff @(posedge tck or posedge reset) begin
    if (reset) starve_cnt <= '0;
    else if (!bus.host_req || grant) starve_cnt <= '0;
    else if (state == IDLE) starve_cnt <= starve_cnt + SW'(1);
  end
  jtag_csr_regfile #(.VERSION(VERSION)) u_regfile (
    .tck(tck),
    .reset(reset),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr_a(csr_addr),
    .rdata_a(bus.csr_data),
    .re_b(state == HOST_RD),
    .raddr_b(h_addr),
    .rdata_b(bus.host_rdata),
    .drop_cnt(drop_cnt),
    .lock(lock)
  );
endmodule
